genius_controller: RTL and testbench

Moore-style control FSM that sequences the Genius game datapath through setup, FPGA sequence playback, user entry, comparison, round advance and result display. It drives the datapath's reset (R1, R2), enable (E1–E4) and display-select (SEL) inputs and consumes its status flags (end_FPGA, end_User, end_time, win, match). It sits beside the datapath in the top level, clocked from CLOCK_50, and takes the debounced/synchronized enter key from the button logic.

---
 rtl/genius_controller.sv | 104 ++++++++++
 tb/tb_genius_controller.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/genius_controller.sv
// Genius game sequencing FSM: drives datapath resets/enables/display select from
// the enter key and the datapath status flags. Outputs are registered per state.
module genius_controller #(
   parameter int CHECK_WAIT = 2
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       enter,
   input  logic       end_FPGA,
   input  logic       end_User,
   input  logic       end_time,
   input  logic       win,
   input  logic       match,
   output logic       R1,
   output logic       R2,
   output logic       E1,
   output logic       E2,
   output logic       E3,
   output logic       E4,
   output logic       SEL,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      S_INIT   = 3'd0,
      S_SETUP  = 3'd1,
      S_SEQ    = 3'd2,
      S_PLAY   = 3'd3,
      S_CHECK  = 3'd4,
      S_NEXT   = 3'd5,
      S_RESULT = 3'd6
   } state_t;

   localparam logic [3:0] WAIT_LOAD = 4'(CHECK_WAIT - 1);

   state_t     r_state;
   state_t     w_next;
   logic       r_enter_q;
   logic [3:0] r_wait;
   logic       w_enter_rise;
   logic       w_check_done;

   // Output pattern per state, ordered {R1, R2, E1, E2, E3, E4, SEL}.
   function automatic logic [6:0] f_decode(input state_t s);
      logic [6:0] v;
      v = 7'b0000000;
      case (s)
         S_INIT:   v = 7'b1100000;
         S_SETUP:  v = 7'b0010000;
         S_SEQ:    v = 7'b0000100;
         S_PLAY:   v = 7'b0001000;
         S_CHECK:  v = 7'b0000000;
         S_NEXT:   v = 7'b0100010;
         S_RESULT: v = 7'b0000001;
         default:  v = 7'b1100000;
      endcase
      return v;
   endfunction

   assign w_enter_rise = enter & ~r_enter_q;
   assign w_check_done = (r_wait == 4'd0);
   assign state_o      = r_state;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_INIT:   w_next = S_SETUP;
         S_SETUP:  if (w_enter_rise) w_next = S_SEQ;
         S_SEQ:    if (end_FPGA) w_next = S_PLAY;
         S_PLAY: begin
            if (end_User)      w_next = S_CHECK;
            else if (end_time) w_next = S_RESULT;
         end
         S_CHECK: begin
            if (w_check_done) begin
               if (match && !win) w_next = S_NEXT;
               else               w_next = S_RESULT;
            end
         end
         S_NEXT:   w_next = S_SEQ;
         S_RESULT: if (w_enter_rise) w_next = S_INIT;
         default:  w_next = S_INIT;
      endcase
   end

   // Outputs are loaded from the next state so they line up with r_state.
   always_ff @(posedge CLOCK_50) begin
      if (!reset) begin
         r_state                         <= S_INIT;
         r_enter_q                       <= 1'b0;
         r_wait                          <= 4'd0;
         {R1, R2, E1, E2, E3, E4, SEL}   <= f_decode(S_INIT);
      end else begin
         r_state                         <= w_next;
         r_enter_q                       <= enter;
         {R1, R2, E1, E2, E3, E4, SEL}   <= f_decode(w_next);
         if (w_next == S_CHECK && r_state != S_CHECK)
            r_wait <= WAIT_LOAD;
         else if (r_state == S_CHECK && !w_check_done)
            r_wait <= r_wait - 4'd1;
      end
   end

endmodule

// File: tb/tb_genius_controller.sv
// Directed bench for genius_controller: per-cycle vector table plus hand-written
// sequences for held-enter and CHECK dwell behaviour.
module tb_genius_controller;

   logic       CLOCK_50 = 1'b0;
   logic       reset    = 1'b0;
   logic       enter    = 1'b0;
   logic       end_FPGA = 1'b0;
   logic       end_User = 1'b0;
   logic       end_time = 1'b0;
   logic       win      = 1'b0;
   logic       match    = 1'b0;
   logic       R1, R2, E1, E2, E3, E4, SEL;
   logic [2:0] state_o;

   int n_pass  = 0;
   int n_total = 0;

   // Expected {R1,R2,E1,E2,E3,E4,SEL} per state.
   localparam logic [6:0] O_INIT   = 7'b1100000;
   localparam logic [6:0] O_SETUP  = 7'b0010000;
   localparam logic [6:0] O_SEQ    = 7'b0000100;
   localparam logic [6:0] O_PLAY   = 7'b0001000;
   localparam logic [6:0] O_CHECK  = 7'b0000000;
   localparam logic [6:0] O_NEXT   = 7'b0100010;
   localparam logic [6:0] O_RESULT = 7'b0000001;

   typedef struct {
      logic       rst, en, ef, eu, et, w, m;
      logic [2:0] st;
      logic [6:0] outs;
   } vec_t;

   vec_t tbl[$];

   genius_controller #(.CHECK_WAIT(2)) dut (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .enter    (enter),
      .end_FPGA (end_FPGA),
      .end_User (end_User),
      .end_time (end_time),
      .win      (win),
      .match    (match),
      .R1       (R1),
      .R2       (R2),
      .E1       (E1),
      .E2       (E2),
      .E3       (E3),
      .E4       (E4),
      .SEL      (SEL),
      .state_o  (state_o)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   function automatic vec_t mk(input logic rst, en, ef, eu, et, w, m,
                               input logic [2:0] st, input logic [6:0] outs);
      vec_t v;
      v.rst = rst; v.en = en; v.ef = ef; v.eu = eu; v.et = et; v.w = w; v.m = m;
      v.st = st; v.outs = outs;
      return v;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic step(input logic rst, en, ef, eu, et, w, m);
      @(negedge CLOCK_50);
      reset = rst; enter = en; end_FPGA = ef; end_User = eu;
      end_time = et; win = w; match = m;
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic check_outs(input string name, input logic [2:0] st,
                             input logic [6:0] outs);
      check({name, " state"}, int'(state_o), int'(st));
      check({name, " outs"}, int'({R1, R2, E1, E2, E3, E4, SEL}), int'(outs));
   endtask

   initial begin
      int n_seq;
      int dwell;
      logic [2:0] prev;

      // Power-up reset, then a full non-final round.
      tbl.push_back(mk(0,0,0,0,0,0,0, 3'd0, O_INIT));
      tbl.push_back(mk(0,0,0,0,0,0,0, 3'd0, O_INIT));
      tbl.push_back(mk(1,0,0,0,0,0,0, 3'd1, O_SETUP));
      tbl.push_back(mk(1,0,0,0,0,0,0, 3'd1, O_SETUP));
      tbl.push_back(mk(1,1,0,0,0,0,0, 3'd2, O_SEQ));
      tbl.push_back(mk(1,0,0,0,0,0,0, 3'd2, O_SEQ));
      tbl.push_back(mk(1,0,0,0,0,0,0, 3'd2, O_SEQ));
      tbl.push_back(mk(1,0,0,0,0,0,0, 3'd2, O_SEQ));
      tbl.push_back(mk(1,0,0,0,0,0,0, 3'd2, O_SEQ));
      tbl.push_back(mk(1,0,1,0,0,0,0, 3'd3, O_PLAY));
      for (int i = 0; i < 7; i++)
         tbl.push_back(mk(1,0,0,0,0,0,0, 3'd3, O_PLAY));
      tbl.push_back(mk(1,0,0,1,0,0,1, 3'd4, O_CHECK));
      tbl.push_back(mk(1,0,0,0,0,0,1, 3'd4, O_CHECK));
      tbl.push_back(mk(1,0,0,0,0,0,1, 3'd5, O_NEXT));
      tbl.push_back(mk(1,0,0,0,0,0,0, 3'd2, O_SEQ));
      // Reset held three cycles from SEQ, then release.
      tbl.push_back(mk(0,0,0,0,0,0,0, 3'd0, O_INIT));
      tbl.push_back(mk(0,0,0,0,0,0,0, 3'd0, O_INIT));
      tbl.push_back(mk(0,0,0,0,0,0,0, 3'd0, O_INIT));
      tbl.push_back(mk(1,0,0,0,0,0,0, 3'd1, O_SETUP));
      // Final round: match & win -> RESULT, enter -> INIT -> SETUP.
      tbl.push_back(mk(1,1,0,0,0,0,0, 3'd2, O_SEQ));
      tbl.push_back(mk(1,0,1,0,0,0,0, 3'd3, O_PLAY));
      tbl.push_back(mk(1,0,0,1,0,1,1, 3'd4, O_CHECK));
      tbl.push_back(mk(1,0,0,0,0,1,1, 3'd4, O_CHECK));
      tbl.push_back(mk(1,0,0,0,0,1,1, 3'd6, O_RESULT));
      tbl.push_back(mk(1,0,0,0,0,0,0, 3'd6, O_RESULT));
      tbl.push_back(mk(1,1,0,0,0,0,0, 3'd0, O_INIT));
      tbl.push_back(mk(1,0,0,0,0,0,0, 3'd1, O_SETUP));
      // Timeout in PLAY.
      tbl.push_back(mk(1,1,0,0,0,0,0, 3'd2, O_SEQ));
      tbl.push_back(mk(1,0,1,0,0,0,0, 3'd3, O_PLAY));
      tbl.push_back(mk(1,0,0,0,1,0,0, 3'd6, O_RESULT));
      tbl.push_back(mk(1,1,0,0,0,0,0, 3'd0, O_INIT));
      tbl.push_back(mk(1,0,0,0,0,0,0, 3'd1, O_SETUP));
      // end_User and end_time together, no match.
      tbl.push_back(mk(1,1,0,0,0,0,0, 3'd2, O_SEQ));
      tbl.push_back(mk(1,0,1,0,0,0,0, 3'd3, O_PLAY));
      tbl.push_back(mk(1,0,0,1,1,0,0, 3'd4, O_CHECK));
      tbl.push_back(mk(1,0,0,0,0,0,0, 3'd4, O_CHECK));
      tbl.push_back(mk(1,0,0,0,0,0,0, 3'd6, O_RESULT));
      tbl.push_back(mk(1,1,0,0,0,0,0, 3'd0, O_INIT));
      tbl.push_back(mk(1,0,0,0,0,0,0, 3'd1, O_SETUP));

      foreach (tbl[i]) begin
         step(tbl[i].rst, tbl[i].en, tbl[i].ef, tbl[i].eu, tbl[i].et,
              tbl[i].w, tbl[i].m);
         check_outs($sformatf("row%0d", i), tbl[i].st, tbl[i].outs);
      end

      // Enter held across SETUP, SEQ, PLAY and into RESULT.
      n_seq = 0;
      prev  = state_o;
      for (int i = 0; i < 20; i++) begin
         step(1, 1, (i == 5), 0, (i == 8), 0, 0);
         if (prev == 3'd1 && state_o == 3'd2) n_seq++;
         prev = state_o;
      end
      check("held enter SETUP->SEQ count", n_seq, 1);
      check_outs("held enter in RESULT", 3'd6, O_RESULT);
      step(1, 0, 0, 0, 0, 0, 0);
      check_outs("release in RESULT", 3'd6, O_RESULT);
      step(1, 1, 0, 0, 0, 0, 0);
      check_outs("re-press in RESULT", 3'd0, O_INIT);
      step(1, 0, 0, 0, 0, 0, 0);
      check_outs("back to SETUP", 3'd1, O_SETUP);

      // CHECK dwell measured with a bounded loop.
      step(1, 1, 0, 0, 0, 0, 0);
      step(1, 0, 1, 0, 0, 0, 0);
      step(1, 0, 0, 1, 0, 1, 1);
      check_outs("enter CHECK", 3'd4, O_CHECK);
      dwell = 1;
      for (int i = 0; i < 20; i++) begin
         step(1, 0, 0, 0, 0, 1, 1);
         if (state_o == 3'd4) dwell++;
         else break;
      end
      check("CHECK dwell", dwell, 2);
      check_outs("after CHECK win", 3'd6, O_RESULT);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
